// File: rtl/parity_frame_rx_if.sv
// Serial-in / framed-word-out bundle for parity_frame_rx.
// The receiver connects through the slave modport; the line driver and consumer use master.
interface parity_frame_rx_if #(
  parameter int DATA_W = 3
);
  logic              bit_en;
  logic              rx_in;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              par_err;
  logic              frm_err;
  logic              overrun;
  logic [2:0]        dbg_state;

  // out_valid/out_ready: a word moves on any rising edge where both are 1. Once raised,
  // out_valid stays high and out_data/par_err/frm_err stay put until that edge happens.
  // out_ready has no effect while out_valid is 0.
  modport master (
    output bit_en, rx_in, out_ready,
    input  out_data, out_valid, par_err, frm_err, overrun, dbg_state
  );

  modport slave (
    input  bit_en, rx_in, out_ready,
    output out_data, out_valid, par_err, frm_err, overrun, dbg_state
  );
endinterface

// File: rtl/parity_frame_rx.sv
// Strobed serial frame receiver: start, DATA_W bits LSB first, even parity, stop.
// Define ERR_COUNT_EN to add the saturating 8-bit err_cnt output.
module parity_frame_rx #(
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  parity_frame_rx_if.slave  bus
`ifdef ERR_COUNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_PARITY = 3'd2,
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
  } state_t;

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MSB_MASK = DATA_W'(1) << (DATA_W - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic              par_bit_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              par_err_q;
  logic              par_err_d;
  logic              frm_err_q;
  logic              frm_err_d;
  logic              overrun_q;
  logic              stop_edge;
  logic              xfer;
  logic              load;
  logic              drop;

  // Bits enter at the MSB so that after DATA_W shifts the first bit sits at bit 0.
  always_comb begin
    stop_edge = bus.bit_en && (state_q == S_STOP);
    xfer      = out_valid_q && bus.out_ready;
    load      = stop_edge && (!out_valid_q || bus.out_ready);
    drop      = stop_edge && out_valid_q && !bus.out_ready;
    shift_d   = (shift_q >> 1) | (bus.rx_in ? MSB_MASK : '0);
    par_err_d = (^shift_q) ^ par_bit_q;
    frm_err_d = ~bus.rx_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_bit_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= drop;
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= shift_q;
        par_err_q   <= par_err_d;
        frm_err_q   <= frm_err_d;
      end else if (xfer) begin
        out_valid_q <= 1'b0;
      end
      if (bus.bit_en) begin
        case (state_q)
          S_IDLE: begin
            cnt_q <= '0;
            if (!bus.rx_in) state_q <= S_DATA;
          end
          S_DATA: begin
            shift_q <= shift_d;
            if (cnt_q == LAST_BIT) begin
              cnt_q   <= '0;
              state_q <= S_PARITY;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_PARITY: begin
            par_bit_q <= bus.rx_in;
            state_q   <= S_STOP;
          end
          S_STOP:  state_q <= bus.rx_in ? S_IDLE : S_BREAK;
          // A held-low line is a break, never a fresh start bit.
          S_BREAK: if (bus.rx_in) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.par_err   = par_err_q;
  assign bus.frm_err   = frm_err_q;
  assign bus.overrun   = overrun_q;
  assign bus.dbg_state = state_q;

`ifdef ERR_COUNT_EN
  logic [7:0] err_cnt_q;
  logic       err_inc;

  // Delivery with an error flag and a drop are both tied to the stop edge, so at most one fires.
  assign err_inc = (load && (par_err_d || frm_err_d)) || drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (err_inc && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx: directed scenarios plus randomized frames
// checked cycle by cycle against a transaction-level reference model.
module tb_parity_frame_rx;
  localparam int DATA_W = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  parity_frame_rx_if #(.DATA_W(DATA_W)) bus ();
`ifdef ERR_COUNT_EN
  logic [7:0] err_cnt;
`endif

  parity_frame_rx #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ERR_COUNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  // Reference model: holding register and error count, advanced once per clock edge.
  logic              m_valid, m_par, m_frm, m_ovr;
  logic [DATA_W-1:0] m_data;
  int                m_err;
  logic [DATA_W-1:0] cur_data;
  logic              cur_par;
  logic [DATA_W+1:0] exp_q[$];
  logic [DATA_W+1:0] got_q[$];

  task automatic model_reset();
    m_valid = 1'b0; m_par = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
    m_data = '0; m_err = 0;
    exp_q.delete(); got_q.delete();
  endtask

  // Called at a negedge; applies inputs for the next rising edge and returns at the following negedge.
  task automatic drive(input logic rx, input logic en, input logic rdy, input logic is_stop);
    logic xfer, ld, dr;
    bus.rx_in = rx; bus.bit_en = en; bus.out_ready = rdy;
    xfer = m_valid && rdy;
    if (bus.out_valid && rdy) got_q.push_back({bus.par_err, bus.frm_err, bus.out_data});
    @(posedge clk);
    ld = is_stop && (!m_valid || rdy);
    dr = is_stop && m_valid && !rdy;
    m_ovr = dr;
    if (ld) begin
      m_valid = 1'b1;
      m_data  = cur_data;
      m_par   = ^{cur_data, cur_par};
      m_frm   = !rx;
      exp_q.push_back({m_par, m_frm, m_data});
      if ((m_par || m_frm) && m_err != 255) m_err++;
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    if (dr && m_err != 255) m_err++;
    @(negedge clk);
  endtask

  // gap unstrobed cycles precede every strobe, with the line driven to the opposite level.
  task automatic send_frame(input logic [DATA_W-1:0] data, input logic parbit,
                            input logic stopbit, input logic rdy, input int gap);
    logic [DATA_W+2:0] fr;
    cur_data = data; cur_par = parbit;
    fr = {stopbit, parbit, data, 1'b0};
    for (int i = 0; i < DATA_W + 3; i++) begin
      for (int g = 0; g < gap; g++) drive(~fr[i], 1'b0, rdy, 1'b0);
      drive(fr[i], 1'b1, rdy, (i == DATA_W + 2));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.rx_in = 1'b1; bus.bit_en = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    #2;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_data got=%b exp=000", bus.out_data); end
    checks++; if ({bus.par_err, bus.frm_err, bus.overrun} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bus.par_err, bus.frm_err, bus.overrun}); end
`ifdef ERR_COUNT_EN
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
`endif
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_good_frame();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(3'b101, 1'b0, 1'b1, 1'b1, 0);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL good_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_data !== 3'b101) begin failures++; $display("FAIL good_data got=%b exp=101", bus.out_data); end
    checks++; if ({bus.par_err, bus.frm_err} !== 2'b00) begin failures++; $display("FAIL good_flags got=%b exp=00", {bus.par_err, bus.frm_err}); end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL good_valid_one_cycle got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_parity_error();
    send_frame(3'b011, 1'b1, 1'b1, 1'b1, 0);
    checks++; if (bus.out_data !== 3'b011) begin failures++; $display("FAIL par_data got=%b exp=011", bus.out_data); end
    checks++; if ({bus.out_valid, bus.par_err, bus.frm_err} !== 3'b110) begin failures++; $display("FAIL par_flags got=%b exp=110", {bus.out_valid, bus.par_err, bus.frm_err}); end
`ifdef ERR_COUNT_EN
    checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL par_err_cnt got=%0d exp=1", err_cnt); end
`endif
    drive(1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_break();
    logic [7:0] tail;
    send_frame(3'b100, 1'b1, 1'b0, 1'b1, 0);
    checks++; if (bus.out_data !== 3'b100) begin failures++; $display("FAIL brk_data got=%b exp=100", bus.out_data); end
    checks++; if ({bus.out_valid, bus.par_err, bus.frm_err} !== 3'b101) begin failures++; $display("FAIL brk_flags got=%b exp=101", {bus.out_valid, bus.par_err, bus.frm_err}); end
    tail = 8'b1111_1100;
    for (int i = 0; i < 8; i++) begin
      drive(tail[i], 1'b1, 1'b1, 1'b0);
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL brk_spurious cycle=%0d got=%b exp=0", i, bus.out_valid); end
    end
    send_frame(3'b010, 1'b1, 1'b1, 1'b1, 0);
    checks++; if ({bus.out_valid, bus.out_data, bus.frm_err} !== 5'b1_010_0) begin failures++; $display("FAIL brk_recover got=%b exp=10100", {bus.out_valid, bus.out_data, bus.frm_err}); end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(3'b001, 1'b1, 1'b1, 1'b0, 0);
    checks++; if ({bus.out_valid, bus.overrun, bus.out_data} !== 5'b1_0_001) begin failures++; $display("FAIL ovr_first got=%b exp=10001", {bus.out_valid, bus.overrun, bus.out_data}); end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(3'b110, 1'b0, 1'b1, 1'b0, 0);
    checks++; if (bus.overrun !== 1'b1) begin failures++; $display("FAIL ovr_pulse got=%b exp=1", bus.overrun); end
    checks++; if ({bus.out_valid, bus.out_data, bus.par_err} !== 5'b1_001_0) begin failures++; $display("FAIL ovr_held got=%b exp=10010", {bus.out_valid, bus.out_data, bus.par_err}); end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if ({bus.overrun, bus.out_data} !== 4'b0_001) begin failures++; $display("FAIL ovr_one_cycle got=%b exp=0001", {bus.overrun, bus.out_data}); end
`ifdef ERR_COUNT_EN
    checks++; if (err_cnt !== 8'(m_err)) begin failures++; $display("FAIL ovr_err_cnt got=%0d exp=%0d", err_cnt, m_err); end
`endif
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ovr_release got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_sparse_strobe();
    send_frame(3'b101, 1'b0, 1'b1, 1'b1, 2);
    checks++; if ({bus.out_valid, bus.out_data, bus.par_err, bus.frm_err} !== 6'b1_101_00) begin failures++; $display("FAIL sparse_frame got=%b exp=110100", {bus.out_valid, bus.out_data, bus.par_err, bus.frm_err}); end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL sparse_valid_clear got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_frame();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(3'b010, 1'b0, 1'b0, 1'b0, 0);
    checks++; if ({bus.out_valid, bus.par_err, bus.frm_err} !== 3'b111) begin failures++; $display("FAIL rmid_pre got=%b exp=111", {bus.out_valid, bus.par_err, bus.frm_err}); end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if ({bus.out_valid, bus.par_err, bus.frm_err, bus.overrun} !== 4'b0000) begin failures++; $display("FAIL rmid_flags got=%b exp=0000", {bus.out_valid, bus.par_err, bus.frm_err, bus.overrun}); end
    checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL rmid_data got=%b exp=000", bus.out_data); end
`ifdef ERR_COUNT_EN
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL rmid_err_cnt got=%0d exp=0", err_cnt); end
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_frame(3'b111, 1'b1, 1'b1, 1'b1, 0);
    checks++; if ({bus.out_valid, bus.out_data, bus.par_err, bus.frm_err} !== 6'b1_111_00) begin failures++; $display("FAIL rmid_next got=%b exp=111100", {bus.out_valid, bus.out_data, bus.par_err, bus.frm_err}); end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [DATA_W+2:0] fr;
    logic [DATA_W-1:0] d;
    logic              p, s, rdy, cyc_bad;
    int                gap, bad_cycles;
    logic [DATA_W+1:0] e, g;
    bad_cycles = 0;
    exp_q.delete(); got_q.delete();
    for (int f = 0; f < 60; f++) begin
      d = DATA_W'($urandom);
      p = (^d) ^ ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 3) != 0);
      cur_data = d; cur_par = p;
      fr = {s, p, d, 1'b0};
      for (int i = -1; i < DATA_W + 3; i++) begin
        gap = $urandom_range(0, 2);
        for (int k = 0; k <= gap; k++) begin
          rdy = ($urandom_range(0, 2) != 0);
          if (k < gap) drive(1'($urandom), 1'b0, rdy, 1'b0);
          else if (i < 0) drive(1'b1, 1'b1, rdy, 1'b0);
          else drive(fr[i], 1'b1, rdy, (i == DATA_W + 2));
          cyc_bad = ({bus.out_valid, bus.overrun} !== {m_valid, m_ovr});
          if (m_valid && ({bus.out_data, bus.par_err, bus.frm_err} !== {m_data, m_par, m_frm})) cyc_bad = 1'b1;
          checks++;
          if (cyc_bad) begin
            failures++; bad_cycles++;
            if (bad_cycles <= 10)
              $display("FAIL rand_cycle frame=%0d got v/o/d/p/f=%b/%b/%b/%b/%b exp=%b/%b/%b/%b/%b",
                       f, bus.out_valid, bus.overrun, bus.out_data, bus.par_err, bus.frm_err,
                       m_valid, m_ovr, m_data, m_par, m_frm);
          end
        end
      end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL rand_frame got=%b exp=%b", g, e); end
    end
`ifdef ERR_COUNT_EN
    checks++; if (err_cnt !== 8'(m_err)) begin failures++; $display("FAIL rand_err_cnt got=%0d exp=%0d", err_cnt, m_err); end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_break();
    test_overrun();
    test_sparse_strobe();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/parity_frame_rx.md
PARITY_FRAME_RX -- requirements
Module: parity_frame_rx

Interface
REQ-001 Parameter DATA_W, default 3, SHALL set the number of data bits per frame (legal range 1..16).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 bit_en  input  1  SHALL be the bit-sample strobe; rx_in is sampled only on edges where bit_en=1.
REQ-005 rx_in  input  1  SHALL be the serial line; idle level 1.
REQ-006 out_data  output  DATA_W  SHALL be the received data word, bit 0 first on the line.
REQ-007 out_valid  output  1  SHALL flag that out_data/par_err/frm_err hold an undelivered frame.
REQ-008 out_ready  input  1  SHALL be the consumer acceptance; a transfer occurs on edges where out_valid=1 and out_ready=1.
REQ-009 par_err  output  1  SHALL flag an even-parity violation in the held frame.
REQ-010 frm_err  output  1  SHALL flag a stop bit sampled as 0 in the held frame.
REQ-011 overrun  output  1  SHALL pulse for one cycle when a completed frame is dropped.

Function
REQ-012 Frame format SHALL be: start bit (0), DATA_W data bits LSB first, one even-parity bit, one stop bit (1).
REQ-013 The FSM SHALL have the states IDLE, DATA, PARITY, STOP and BREAK.
REQ-014 IDLE SHALL go to DATA on a sample of 0; a sample of 1 SHALL keep it in IDLE.
REQ-015 DATA SHALL shift in DATA_W samples, tracked by a bit counter, then go to PARITY.
REQ-016 PARITY SHALL capture one sample and go to STOP.
REQ-017 STOP SHALL go to IDLE on a sample of 1, and to BREAK on a sample of 0.
REQ-018 BREAK SHALL stay until a sample of 1, then go to IDLE; a low line SHALL never be taken as a new start bit.
REQ-019 When bit_en=0 the FSM, counter and shift register SHALL hold; rx_in SHALL be ignored.
REQ-020 par_err SHALL equal the XOR of all data bits and the parity bit (0 = parity correct).
REQ-021 On the edge sampling the stop bit, the frame SHALL be loaded into the holding register if out_valid=0, or if out_valid=1 and out_ready=1 on that same edge.
REQ-022 Latency: out_valid SHALL be 1 in the cycle immediately after the stop-bit sampling edge.
REQ-023 A frame with frm_err=1 and/or par_err=1 SHALL still be delivered, with its flags set.
REQ-024 If the holding register is full and not accepted on the stop-bit edge, the new frame SHALL be dropped, the held frame SHALL be preserved, and overrun SHALL pulse for one cycle.
REQ-025 out_valid SHALL clear after a transfer unless a new frame loads on the same edge.
REQ-026 out_data, par_err and frm_err SHALL remain stable while out_valid=1 and no transfer occurs.
REQ-027 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-028 rst SHALL force IDLE, bit counter 0, shift register 0, out_data 0, out_valid 0, par_err 0, frm_err 0 and overrun 0 immediately.
REQ-029 Reset mid-frame SHALL discard the partial frame, and no output SHALL result from it.
REQ-030 After rst deasserts, the first sampled 0 SHALL be treated as a start bit.

Configuration
REQ-031 Macro ERR_COUNT_EN defined SHALL add the output port err_cnt (8 bits).
REQ-032 With ERR_COUNT_EN, err_cnt SHALL increment by 1 per delivered frame with par_err or frm_err set, and by 1 per overrun.
REQ-033 err_cnt SHALL saturate at 255, SHALL clear only on rst, and SHALL increment by at most 1 per edge.
REQ-034 Without ERR_COUNT_EN, the err_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (DATA_W=3, bit_en=1 every cycle unless stated)
REQ-035 Line 0,1,0,1,0,1 with out_ready=1 -> out_data=3'b101, par_err=0, frm_err=0, out_valid high exactly 1 cycle after the stop edge.
REQ-036 Line 0,1,1,0,1,1 -> out_data=3'b011, par_err=1; with ERR_COUNT_EN, err_cnt=1.
REQ-037 Line 0,0,0,1,1,0 then 0,0,1 -> out_data=3'b100, frm_err=1; FSM stays in BREAK through the 0s and returns to IDLE on the 1; no spurious frame.
REQ-038 out_ready=0, then two good frames 3'b001 and 3'b110 -> the first frame is held, overrun pulses once at the second stop edge, and out_data stays 3'b001.
REQ-039 bit_en=1 on every third cycle only, rx_in toggling between strobes -> result matches REQ-035, so unstrobed values are ignored.
REQ-040 rst asserted after 2 data bits -> all outputs 0 at once; the next complete frame 3'b111 with parity 1 is received correctly.
